// File: rtl/vmem_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads first, then the clear/fill engine,
// then the buffered pixel-write FIFO. Scanout is never stalled.
module vmem_arbiter #(
    parameter int H_W        = 10,
    parameter int V_W        = 9,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = H_W + V_W,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vga_valid,
    input  logic [H_W-1:0]    h_addr,
    input  logic [V_W-1:0]    v_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [H_W-1:0]    wr_h,
    input  logic [V_W-1:0]    wr_v,
    input  logic [DATA_W-1:0] wr_data,
    output logic [CW-1:0]     wr_count,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     fill_addr;
    logic [DATA_W-1:0] fill_color;
    logic              fill_last;
    wr_req_t           fifo_mem [FIFO_DEPTH];
    wr_req_t           head;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop;
    logic              rd_gnt, fill_gnt;
    logic              rd_d1;

    // wr_ready looks at occupancy only, so a same-cycle pop never lets a push in on a full FIFO
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = resetn && !full;
    assign wr_count = count;
    assign push     = wr_valid && wr_ready;
    assign head     = fifo_mem[rd_ptr];

    assign rd_gnt   = vga_valid;
    assign fill_gnt = !vga_valid && (state == FILL);
    assign pop      = !vga_valid && (state == IDLE) && !empty;
    assign fill_last = (fill_addr == '1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req) state_nxt = FILL;
            FILL:    if (fill_gnt && fill_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (state == FILL);
    end

    // fill_addr parks at the last address; it is re-zeroed by the next accepted clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_addr  <= '0;
            fill_color <= '0;
        end else if (state == IDLE && clear_req) begin
            fill_addr  <= '0;
            fill_color <= clear_color;
        end else if (fill_gnt && !fill_last) begin
            fill_addr  <= fill_addr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr].addr <= {wr_h, wr_v};
            fifo_mem[wr_ptr].data <= wr_data;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_gnt) begin
            mem_en   = 1'b1;
            mem_addr = {h_addr, v_addr};
        end else if (fill_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fill_addr;
            mem_wdata = fill_color;
        end else if (pop) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end
    end

    // RAM read data arrives the cycle after the grant; register it once more for vga_ctrl
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_d1    <= 1'b0;
            vga_data <= '0;
        end else begin
            rd_d1    <= rd_gnt;
            vga_data <= rd_d1 ? mem_rdata : '0;
        end
    end

endmodule
